// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Used by uart_rx_sampler and uart_sipo_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/uart_sipo_rx_if.sv
// Receiver-to-register-block bundle: byte, status, valid pulse.
// master drives the bundle, slave consumes it.
interface uart_sipo_rx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err
  );

  modport slave (
    input data_out,
    input data_valid,
    input parity_err,
    input frame_err
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line sampler: optional synchroniser (UART_RX_SYNC_EN), rx_prev,
// per-state tick counter and the half/full bit strobes.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic baud_clk,
  input  logic reset_n,
  input  logic data_rx,
  input  logic run,
  input  logic clr,
  output logic rx_s,
  output logic rx_prev,
  output logic half_tick,
  output logic full_tick
);

  localparam int TW = $clog2(OVERSAMPLE);

  logic [TW-1:0] tick;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {2{LINE_IDLE}};
    end else begin
      sync <= {sync[0], data_rx};
    end
  end

  assign rx_s = sync[1];
`else
  assign rx_s = data_rx;
`endif

  assign half_tick = (tick == TW'(OVERSAMPLE / 2 - 1));
  assign full_tick = (tick == TW'(OVERSAMPLE - 1));

  // tick restarts on every state change and rests at 0 in IDLE
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev <= LINE_IDLE;
      tick    <= '0;
    end else begin
      rx_prev <= rx_s;
      if (clr || !run) begin
        tick <= '0;
      end else if (full_tick) begin
        tick <= '0;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_sipo_rx.sv
// UART receiver: start, DATA_W bits LSB-first, parity, stop.
// Build option UART_RX_SYNC_EN adds a 2-flop input synchroniser.
module uart_sipo_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic            baud_clk,
  input  logic            reset_n,
  input  logic            data_rx,
  input  logic            parity_type,
  uart_sipo_rx_if.master  rx_if,
  output logic            active_flag,
  output logic            done_flag
);

  localparam int CW = $clog2(DATA_W + 1);

  rx_state_t         state;
  rx_state_t         state_nx;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              rx_s;
  logic              rx_prev;
  logic              half_tick;
  logic              full_tick;
  logic              ones_odd;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .data_rx  (data_rx),
    .run      (state != IDLE),
    .clr      (state_nx != state),
    .rx_s     (rx_s),
    .rx_prev  (rx_prev),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  assign active_flag = (state != IDLE);
  assign done_flag   = (state == IDLE);
  assign ones_odd    = ^shreg ^ par_bit;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        // edge-triggered so a held-low break never restarts
        if (rx_prev == LINE_IDLE && rx_s != LINE_IDLE)
          state_nx = START;
      end
      START: begin
        if (half_tick)
          state_nx = (rx_s == LINE_IDLE) ? IDLE : DATA;
      end
      DATA: begin
        if (full_tick && bit_cnt == CW'(DATA_W - 1))
          state_nx = PARITY;
      end
      PARITY: begin
        if (full_tick)
          state_nx = STOP;
      end
      STOP: begin
        if (full_tick)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt          <= '0;
      shreg            <= '0;
      par_bit          <= 1'b0;
      rx_if.data_out   <= '0;
      rx_if.data_valid <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
    end else begin
      rx_if.data_valid <= 1'b0;
      unique case (state)
        START: begin
          if (half_tick)
            bit_cnt <= '0;
        end
        DATA: begin
          if (full_tick) begin
            shreg   <= {rx_s, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (full_tick)
            par_bit <= rx_s;
        end
        STOP: begin
          if (full_tick) begin
            rx_if.data_out   <= shreg;
            rx_if.parity_err <= (parity_type == PARITY_EVEN)
                                ? ones_odd : ~ones_odd;
            rx_if.frame_err  <= ~rx_s;
            rx_if.data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// Self-checking bench for uart_sipo_rx, directed plus random frames.
// Honours UART_RX_SYNC_EN by shifting expected latency by 2 cycles.
module tb_uart_sipo_rx;

  localparam int OS = 16;
  localparam int DW = 8;
`ifdef UART_RX_SYNC_EN
  localparam int SYN = 2;
`else
  localparam int SYN = 0;
`endif
  localparam int LAT = 1 + OS / 2 + (DW + 2) * OS + SYN;

  logic baud_clk    = 1'b0;
  logic reset_n     = 1'b0;
  logic data_rx     = 1'b1;
  logic parity_type = 1'b0;
  logic active_flag;
  logic done_flag;

  uart_sipo_rx_if #(.DATA_W(DW)) rx_if ();

  uart_sipo_rx #(
    .OVERSAMPLE(OS),
    .DATA_W    (DW)
  ) dut (
    .baud_clk   (baud_clk),
    .reset_n    (reset_n),
    .data_rx    (data_rx),
    .parity_type(parity_type),
    .rx_if      (rx_if),
    .active_flag(active_flag),
    .done_flag  (done_flag)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  logic [7:0] obs_d[$];
  bit         obs_pe[$];
  bit         obs_fe[$];
  int         obs_c[$];

  always @(negedge baud_clk) begin
    if (rx_if.data_valid === 1'b1) begin
      obs_d.push_back(rx_if.data_out);
      obs_pe.push_back(rx_if.parity_err);
      obs_fe.push_back(rx_if.frame_err);
      obs_c.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic clr_obs();
    obs_d.delete();
    obs_pe.delete();
    obs_fe.delete();
    obs_c.delete();
  endtask

  task automatic drive(input bit b, input int n);
    data_rx = b;
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit par,
                      input bit stp, output int c0);
    c0 = cyc;
    drive(1'b0, OS);
    for (int i = 0; i < DW; i++) drive(d[i], OS);
    drive(par, OS);
    drive(stp, OS);
  endtask

  task automatic wait_obs(input int n, input int budget);
    while (obs_d.size() < n && budget > 0) begin
      @(posedge baud_clk);
      #1;
      budget--;
    end
  endtask

  // parity bit that makes the frame correct for the given mode
  function automatic bit good_par(logic [7:0] d, bit pt);
    return (($countones(d) % 2) == 1) ^ pt;
  endfunction

  function automatic bit exp_perr(logic [7:0] d, bit par, bit pt);
    int ones;
    ones = $countones(d) + int'(par);
    return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic test_reset();
    tests++;
    if (rx_if.data_out !== 8'h00) begin
      fails++;
      $display("FAIL rst_data got %h want 00", rx_if.data_out);
    end
    tests++;
    if (rx_if.data_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b want 0", rx_if.data_valid);
    end
    tests++;
    if ({rx_if.parity_err, rx_if.frame_err} !== 2'b00) begin
      fails++;
      $display("FAIL rst_err got %b%b want 00",
               rx_if.parity_err, rx_if.frame_err);
    end
    tests++;
    if ({active_flag, done_flag} !== 2'b01) begin
      fails++;
      $display("FAIL rst_flags got %b%b want 01",
               active_flag, done_flag);
    end
  endtask

  task automatic test_basic();
    int c0;
    clr_obs();
    parity_type = 1'b0;
    send(8'hA5, 1'b0, 1'b1, c0);
    drive(1'b1, 20);
    tests++;
    if (obs_d.size() != 1) begin
      fails++;
      $display("FAIL a5_count got %0d want 1", obs_d.size());
    end else begin
      tests++;
      if (obs_d[0] !== 8'hA5 || obs_pe[0] !== 1'b0 ||
          obs_fe[0] !== 1'b0) begin
        fails++;
        $display("FAIL a5_frame got %h/%b/%b want a5/0/0",
                 obs_d[0], obs_pe[0], obs_fe[0]);
      end
      tests++;
      if (obs_c[0] != c0 + LAT) begin
        fails++;
        $display("FAIL a5_latency got %0d want %0d",
                 obs_c[0] - c0, LAT);
      end
    end
    clr_obs();
    parity_type = 1'b1;
    send(8'h3C, 1'b0, 1'b1, c0);
    drive(1'b1, 20);
    tests++;
    if (obs_d.size() != 1) begin
      fails++;
      $display("FAIL 3c_count got %0d want 1", obs_d.size());
    end else begin
      tests++;
      if (obs_d[0] !== 8'h3C || obs_pe[0] !== 1'b1 ||
          obs_fe[0] !== 1'b0) begin
        fails++;
        $display("FAIL 3c_frame got %h/%b/%b want 3c/1/0",
                 obs_d[0], obs_pe[0], obs_fe[0]);
      end
    end
  endtask

  task automatic test_break();
    int c0;
    clr_obs();
    parity_type = 1'b0;
    send(8'h55, 1'b0, 1'b0, c0);
    drive(1'b0, 40);
    tests++;
    if (obs_d.size() != 1) begin
      fails++;
      $display("FAIL brk_count got %0d want 1", obs_d.size());
    end
    drive(1'b1, 16);
    send(8'h81, 1'b0, 1'b1, c0);
    drive(1'b1, 20);
    tests++;
    if (obs_d.size() != 2) begin
      fails++;
      $display("FAIL brk_total got %0d want 2", obs_d.size());
    end else begin
      tests++;
      if (obs_d[0] !== 8'h55 || obs_fe[0] !== 1'b1 ||
          obs_pe[0] !== 1'b0) begin
        fails++;
        $display("FAIL brk_first got %h/%b/%b want 55/0/1",
                 obs_d[0], obs_pe[0], obs_fe[0]);
      end
      tests++;
      if (obs_d[1] !== 8'h81 || obs_fe[1] !== 1'b0 ||
          obs_pe[1] !== 1'b0) begin
        fails++;
        $display("FAIL brk_second got %h/%b/%b want 81/0/0",
                 obs_d[1], obs_pe[1], obs_fe[1]);
      end
    end
  endtask

  task automatic test_glitch();
    int low;
    low = 0;
    clr_obs();
    data_rx = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 4) data_rx = 1'b1;
      @(posedge baud_clk);
      #1;
      if (done_flag !== 1'b1) low++;
    end
    tests++;
    if (low != OS / 2) begin
      fails++;
      $display("FAIL glitch_busy got %0d want %0d", low, OS / 2);
    end
    drive(1'b1, 200);
    tests++;
    if (obs_d.size() != 0) begin
      fails++;
      $display("FAIL glitch_valid got %0d want 0", obs_d.size());
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    clr_obs();
    parity_type = 1'b0;
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(1'b1, OS);
    drive(1'b1, 5);
    reset_n = 1'b0;
    #1;
    tests++;
    if (rx_if.data_out !== 8'h00 || rx_if.data_valid !== 1'b0 ||
        rx_if.parity_err !== 1'b0 || rx_if.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL midrst_out got %h/%b/%b/%b want 00/0/0/0",
               rx_if.data_out, rx_if.data_valid,
               rx_if.parity_err, rx_if.frame_err);
    end
    tests++;
    if ({active_flag, done_flag} !== 2'b01) begin
      fails++;
      $display("FAIL midrst_flags got %b%b want 01",
               active_flag, done_flag);
    end
    drive(1'b1, 40);
    reset_n = 1'b1;
    drive(1'b1, 8);
    send(8'h0F, 1'b0, 1'b1, c0);
    drive(1'b1, 20);
    tests++;
    if (obs_d.size() != 1) begin
      fails++;
      $display("FAIL midrst_count got %0d want 1", obs_d.size());
    end else begin
      tests++;
      if (obs_d[0] !== 8'h0F || obs_pe[0] !== 1'b0 ||
          obs_fe[0] !== 1'b0) begin
        fails++;
        $display("FAIL midrst_frame got %h/%b/%b want 0f/0/0",
                 obs_d[0], obs_pe[0], obs_fe[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int c1;
    clr_obs();
    parity_type = 1'b0;
    send(8'h01, good_par(8'h01, 1'b0), 1'b1, c0);
    send(8'hFE, good_par(8'hFE, 1'b0), 1'b1, c1);
    drive(1'b1, 20);
    tests++;
    if (obs_d.size() != 2) begin
      fails++;
      $display("FAIL b2b_count got %0d want 2", obs_d.size());
    end else begin
      tests++;
      if (obs_d[0] !== 8'h01 || obs_d[1] !== 8'hFE) begin
        fails++;
        $display("FAIL b2b_order got %h,%h want 01,fe",
                 obs_d[0], obs_d[1]);
      end
      tests++;
      if (obs_c[1] - obs_c[0] != (DW + 3) * OS) begin
        fails++;
        $display("FAIL b2b_gap got %0d want %0d",
                 obs_c[1] - obs_c[0], (DW + 3) * OS);
      end
      tests++;
      if ({obs_pe[0], obs_fe[0], obs_pe[1], obs_fe[1]} !== 4'b0) begin
        fails++;
        $display("FAIL b2b_err got %b%b%b%b want 0000",
                 obs_pe[0], obs_fe[0], obs_pe[1], obs_fe[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit pt;
    bit par;
    bit stp;
    bit epe;
    int c0;
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      pt  = 1'($urandom % 2);
      par = good_par(d, pt) ^ ($urandom % 4 == 0);
      stp = ($urandom % 5 != 0);
      epe = exp_perr(d, par, pt);
      parity_type = pt;
      clr_obs();
      send(d, par, stp, c0);
      wait_obs(1, 20);
      tests++;
      if (obs_d.size() != 1) begin
        fails++;
        $display("FAIL rnd%0d_count got %0d want 1", n, obs_d.size());
      end else if (obs_d[0] !== d || obs_pe[0] !== epe ||
                   obs_fe[0] !== !stp) begin
        fails++;
        $display("FAIL rnd%0d_frame got %h/%b/%b want %h/%b/%b",
                 n, obs_d[0], obs_pe[0], obs_fe[0], d, epe, !stp);
      end
      drive(1'b1, $urandom_range(1, 20));
    end
  endtask

  initial begin
    repeat (3) @(posedge baud_clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    drive(1'b1, 5);
    test_basic();
    test_break();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
